// File: rtl/synth_pkg.sv
// synth_pkg
//   Shared definitions for the command path between spi_in and cmd_decoder:
//   the sequencer opcode page, the opcodes within that page, the opcode used
//   for sequencer-generated osc0 tune commands, and the sequencer FSM states.
//   Step writes occupy the low opcodes of the page: 0x0 up to STEPS-1.

package synth_pkg;

    localparam logic [3:0] SEQ_PAGE_DEFAULT = 4'h4;
    localparam logic [7:0] TUNE_CMD_DEFAULT = 8'h01;

    localparam logic [3:0] OP_TEMPO_WR = 4'h8;
    localparam logic [3:0] OP_CTRL_WR  = 4'h9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/seq_tempo_timer.sv
// seq_tempo_timer
//   Tempo generator for the step sequencer. Holds the tempo reload register
//   and a down-counter whose period is {tempo, 8'h00} clocks. Emits a one
//   cycle tick each time the counter wraps. A zero tempo freezes the counter.
// Ports
//   clk         in   1    system clock
//   rst_n       in   1    asynchronous active-low reset
//   tempo_wr    in   1    load tempo_data into the reload register
//   tempo_data  in   DW   new tempo value
//   start       in   1    load the counter for a fresh run
//   enable      in   1    count while high (sequencer running)
//   tick        out  1    counter expired this cycle

module seq_tempo_timer #(
    parameter int DW = 16,
    parameter int TW = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tempo_wr,
    input  logic [DW-1:0] tempo_data,
    input  logic          start,
    input  logic          enable,
    output logic          tick
);

    logic [DW-1:0] tempo_reg;
    logic [TW-1:0] count;
    logic [TW-1:0] period;
    logic          tempo_zero;

    assign period     = TW'({tempo_reg, 8'h00});
    assign tempo_zero = (tempo_reg == '0);
    assign tick       = enable && !start && !tempo_zero && (count == '0);

    // The counter always reloads from the current register value, so a tempo
    // write during a run only changes the period from the next wrap onward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tempo_reg <= '0;
            count     <= '0;
        end else begin
            if (tempo_wr) begin
                tempo_reg <= tempo_data;
            end
            if (start) begin
                count <= tempo_zero ? '0 : (period - TW'(1));
            end else if (enable && !tempo_zero) begin
                if (count == '0) begin
                    count <= period - TW'(1);
                end else begin
                    count <= count - TW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/cmd_seq_arbiter.sv
// cmd_seq_arbiter
//   Sits between spi_in and cmd_decoder. Forwards host commands with one cycle
//   of latency, consumes the sequencer opcode page, and runs a step sequencer
//   that emits osc0 tune commands at a programmable tempo. Host commands
//   always win the output slot; a sequencer step waits in a pending flag.
// Ports
//   clk            in   1            system clock
//   rst_n          in   1            asynchronous active-low reset
//   in_cmd_word    in   8            command from spi_in
//   in_data_word   in   DATA_WIDTH   data from spi_in
//   in_cmd_valid   in   1            strobe from spi_in
//   out_cmd_word   out  8            command to cmd_decoder
//   out_data_word  out  DATA_WIDTH   data to cmd_decoder
//   out_cmd_valid  out  1            one-cycle strobe to cmd_decoder
//   seq_busy       out  1            sequencer is running
//   seq_step       out  log2(STEPS)  index of the last issued step
//   seq_overrun    out  1            sticky: a pending step was overwritten

module cmd_seq_arbiter
    import synth_pkg::*;
#(
    parameter int          DATA_WIDTH  = 16,
    parameter int          STEPS       = 8,
    parameter int          TEMPO_WIDTH = 24,
    parameter logic [7:0]  TUNE_CMD    = TUNE_CMD_DEFAULT,
    parameter logic [3:0]  SEQ_PAGE    = SEQ_PAGE_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [7:0]                in_cmd_word,
    input  logic [DATA_WIDTH-1:0]     in_data_word,
    input  logic                      in_cmd_valid,
    output logic [7:0]                out_cmd_word,
    output logic [DATA_WIDTH-1:0]     out_data_word,
    output logic                      out_cmd_valid,
    output logic                      seq_busy,
    output logic [$clog2(STEPS)-1:0]  seq_step,
    output logic                      seq_overrun
);

    localparam int         IDX_W   = $clog2(STEPS);
    localparam logic [4:0] STEPS_U = 5'(STEPS);

    seq_state_t state, state_next;

    logic [DATA_WIDTH-1:0] step_ram [STEPS];
    logic [IDX_W-1:0]      idx, idx_next;
    logic [IDX_W-1:0]      last_idx, ctrl_last;
    logic                  loop_reg;
    logic                  pending;

    logic       page_hit, host_fwd, tempo_wr, ctrl_wr, step_wr, stop;
    logic       ctrl_run, ctrl_loop;
    logic [3:0] op, ctrl_len_m1;
    logic       tick, step_new, timer_start, seq_issue;

    assign op          = in_cmd_word[3:0];
    assign page_hit    = in_cmd_valid && (in_cmd_word[7:4] == SEQ_PAGE);
    assign host_fwd    = in_cmd_valid && !page_hit;
    assign tempo_wr    = page_hit && (op == OP_TEMPO_WR);
    assign ctrl_wr     = page_hit && (op == OP_CTRL_WR);
    assign step_wr     = page_hit && !tempo_wr && !ctrl_wr && ({1'b0, op} < STEPS_U);
    assign ctrl_run    = in_data_word[0];
    assign ctrl_loop   = in_data_word[1];
    assign ctrl_len_m1 = in_data_word[7:4];
    assign stop        = ctrl_wr && !ctrl_run;

    // A pending step only issues in a slot the host is not using, and never
    // on the cycle a stop arrives.
    assign seq_issue = pending && !host_fwd && !stop;
    assign seq_busy  = (state == RUN);

    // Requested sequence lengths beyond the RAM depth play the whole RAM.
    always_comb begin
        if ({1'b0, ctrl_len_m1} >= STEPS_U) begin
            ctrl_last = IDX_W'(STEPS - 1);
        end else begin
            ctrl_last = ctrl_len_m1[IDX_W-1:0];
        end
    end

    seq_tempo_timer #(
        .DW (DATA_WIDTH),
        .TW (TEMPO_WIDTH)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .tempo_wr   (tempo_wr),
        .tempo_data (in_data_word),
        .start      (timer_start),
        .enable     (seq_busy),
        .tick       (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Every entry into RUN restarts at step 0 and queues it immediately; the
    // following steps are queued on each tempo tick.
    always_comb begin
        state_next  = state;
        idx_next    = idx;
        step_new    = 1'b0;
        timer_start = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl_wr && ctrl_run) begin
                    state_next  = RUN;
                    idx_next    = '0;
                    step_new    = 1'b1;
                    timer_start = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (tick) begin
                    if (idx == last_idx) begin
                        if (loop_reg) begin
                            idx_next = '0;
                            step_new = 1'b1;
                        end else begin
                            state_next = DONE;
                        end
                    end else begin
                        idx_next = idx + IDX_W'(1);
                        step_new = 1'b1;
                    end
                end
            end
            DONE: begin
                if (ctrl_wr) begin
                    if (ctrl_run) begin
                        state_next  = RUN;
                        idx_next    = '0;
                        step_new    = 1'b1;
                        timer_start = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loop_reg <= 1'b0;
            last_idx <= '0;
            for (int i = 0; i < STEPS; i++) begin
                step_ram[i] <= '0;
            end
        end else begin
            if (ctrl_wr) begin
                loop_reg <= ctrl_loop;
                last_idx <= ctrl_last;
            end
            if (step_wr) begin
                step_ram[op[IDX_W-1:0]] <= in_data_word;
            end
        end
    end

    // A step that issues on the same edge a new one is queued is not lost,
    // so only an unissued pending step counts as overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= 1'b0;
            seq_overrun <= 1'b0;
        end else begin
            if (stop) begin
                pending <= 1'b0;
            end else if (step_new) begin
                pending <= 1'b1;
            end else if (seq_issue) begin
                pending <= 1'b0;
            end
            if (ctrl_wr) begin
                seq_overrun <= 1'b0;
            end else if (step_new && pending && !seq_issue) begin
                seq_overrun <= 1'b1;
            end
        end
    end

    // The step data is read at issue time so RAM writes during a run are
    // picked up the next time that step plays.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cmd_word  <= '0;
            out_data_word <= '0;
            out_cmd_valid <= 1'b0;
            seq_step      <= '0;
        end else if (host_fwd) begin
            out_cmd_word  <= in_cmd_word;
            out_data_word <= in_data_word;
            out_cmd_valid <= 1'b1;
        end else if (seq_issue) begin
            out_cmd_word  <= TUNE_CMD;
            out_data_word <= step_ram[idx];
            out_cmd_valid <= 1'b1;
            seq_step      <= idx;
        end else begin
            out_cmd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cmd_seq_arbiter.sv
// tb_cmd_seq_arbiter
//   Directed bench for cmd_seq_arbiter. Each task drives one scenario and
//   checks the expected command stream, timing and status flags inline.

module tb_cmd_seq_arbiter;
    import synth_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_cmd_word;
    logic [15:0] in_data_word;
    logic        in_cmd_valid;
    logic [7:0]  out_cmd_word;
    logic [15:0] out_data_word;
    logic        out_cmd_valid;
    logic        seq_busy;
    logic [2:0]  seq_step;
    logic        seq_overrun;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int          ev_cyc  [$];
    logic [7:0]  ev_cmd  [$];
    logic [15:0] ev_data [$];
    logic [2:0]  ev_step [$];

    cmd_seq_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_cmd_word   (in_cmd_word),
        .in_data_word  (in_data_word),
        .in_cmd_valid  (in_cmd_valid),
        .out_cmd_word  (out_cmd_word),
        .out_data_word (out_data_word),
        .out_cmd_valid (out_cmd_valid),
        .seq_busy      (seq_busy),
        .seq_step      (seq_step),
        .seq_overrun   (seq_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output log, sampled shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (out_cmd_valid === 1'b1) begin
            ev_cyc.push_back(cyc);
            ev_cmd.push_back(out_cmd_word);
            ev_data.push_back(out_data_word);
            ev_step.push_back(seq_step);
        end
    end

    task automatic clear_log();
        ev_cyc.delete();
        ev_cmd.delete();
        ev_data.delete();
        ev_step.delete();
    endtask

    task automatic send(input logic [7:0] c, input logic [15:0] d);
        @(negedge clk);
        in_cmd_word  = c;
        in_data_word = d;
        in_cmd_valid = 1'b1;
        @(negedge clk);
        in_cmd_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        do @(negedge clk); while (cyc < target);
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        in_cmd_word  = '0;
        in_data_word = '0;
        in_cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (out_cmd_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_valid: got %b want 0", out_cmd_valid);
        end
        total++;
        if (out_cmd_word !== 8'h00 || out_data_word !== 16'h0000) begin
            bad++; $display("[TB] FAIL reset_out: got %h/%h want 00/0000", out_cmd_word, out_data_word);
        end
        total++;
        if (seq_busy !== 1'b0 || seq_step !== 3'd0 || seq_overrun !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_status: got %b/%0d/%b want 0/0/0", seq_busy, seq_step, seq_overrun);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_passthrough();
        clear_log();
        send(8'h01, 16'h1234);
        total++;
        if (out_cmd_valid !== 1'b1 || out_cmd_word !== 8'h01 || out_data_word !== 16'h1234) begin
            bad++; $display("[TB] FAIL pass_out: got %b %h/%h want 1 01/1234", out_cmd_valid, out_cmd_word, out_data_word);
        end
        @(negedge clk);
        total++;
        if (out_cmd_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL pass_one_cycle: got %b want 0", out_cmd_valid);
        end
        send(8'h45, 16'hBEEF);
        total++;
        if (out_cmd_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL page_no_fwd: got %b want 0", out_cmd_valid);
        end
        send(8'h4A, 16'h5555);
        send(8'h40, 16'h0100);
        send(8'h41, 16'h0200);
        send(8'h42, 16'h0300);
        send(8'h43, 16'h0400);
        send(8'h48, 16'h0001);
        repeat (3) @(negedge clk);
        total++;
        if (ev_cyc.size() != 1) begin
            bad++; $display("[TB] FAIL page_consumed: got %0d outputs want 1", ev_cyc.size());
        end
        total++;
        if (seq_busy !== 1'b0) begin
            bad++; $display("[TB] FAIL idle_busy: got %b want 0", seq_busy);
        end
    endtask

    task automatic test_run_loop();
        int c0;
        int n;
        logic [15:0] exp_d;
        clear_log();
        send(8'h49, 16'h0033);
        c0 = cyc;
        repeat (1040) @(negedge clk);
        total++;
        if (ev_cyc.size() != 5) begin
            bad++; $display("[TB] FAIL loop_count: got %0d want 5", ev_cyc.size());
        end
        n = (ev_cyc.size() < 5) ? ev_cyc.size() : 5;
        for (int i = 0; i < n; i++) begin
            exp_d = {8'((i % 4) + 1), 8'h00};
            total++;
            if (ev_cmd[i] !== 8'h01 || ev_data[i] !== exp_d) begin
                bad++; $display("[TB] FAIL loop_cmd%0d: got %h/%h want 01/%h", i, ev_cmd[i], ev_data[i], exp_d);
            end
            total++;
            if (ev_cyc[i] != c0 + 1 + 256 * i) begin
                bad++; $display("[TB] FAIL loop_time%0d: got %0d want %0d", i, ev_cyc[i] - c0, 1 + 256 * i);
            end
            total++;
            if (ev_step[i] !== 3'(i % 4)) begin
                bad++; $display("[TB] FAIL loop_step%0d: got %0d want %0d", i, ev_step[i], i % 4);
            end
        end
        total++;
        if (seq_busy !== 1'b1) begin
            bad++; $display("[TB] FAIL loop_busy: got %b want 1", seq_busy);
        end
        send(8'h49, 16'h0000);
        total++;
        if (seq_busy !== 1'b0) begin
            bad++; $display("[TB] FAIL stop_busy: got %b want 0", seq_busy);
        end
    endtask

    task automatic test_one_shot();
        int c0;
        int n;
        clear_log();
        send(8'h49, 16'h0031);
        c0 = cyc;
        repeat (1064) @(negedge clk);
        total++;
        if (ev_cyc.size() != 4) begin
            bad++; $display("[TB] FAIL oneshot_count: got %0d want 4", ev_cyc.size());
        end
        n = (ev_cyc.size() < 4) ? ev_cyc.size() : 4;
        for (int i = 0; i < n; i++) begin
            total++;
            if (ev_data[i] !== {8'(i + 1), 8'h00} || ev_cyc[i] != c0 + 1 + 256 * i) begin
                bad++; $display("[TB] FAIL oneshot_ev%0d: got %h@%0d want %h@%0d", i, ev_data[i], ev_cyc[i] - c0, {8'(i + 1), 8'h00}, 1 + 256 * i);
            end
        end
        total++;
        if (seq_busy !== 1'b0) begin
            bad++; $display("[TB] FAIL oneshot_busy: got %b want 0", seq_busy);
        end
        total++;
        if (dut.state !== DONE) begin
            bad++; $display("[TB] FAIL oneshot_state: got %0d want %0d", dut.state, DONE);
        end
        send(8'h49, 16'h0000);
        total++;
        if (dut.state !== IDLE) begin
            bad++; $display("[TB] FAIL done_to_idle: got %0d want %0d", dut.state, IDLE);
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        clear_log();
        send(8'h49, 16'h0033);
        c0 = cyc;
        wait_cyc(c0 + 255);
        in_cmd_word  = 8'h02;
        in_data_word = 16'hAAAA;
        in_cmd_valid = 1'b1;
        @(negedge clk);
        in_cmd_word  = 8'h03;
        in_data_word = 16'hBBBB;
        @(negedge clk);
        in_cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (ev_cyc.size() != 4) begin
            bad++; $display("[TB] FAIL coll_count: got %0d want 4", ev_cyc.size());
        end else begin
            total++;
            if (ev_cmd[1] !== 8'h02 || ev_data[1] !== 16'hAAAA || ev_cyc[1] != c0 + 256) begin
                bad++; $display("[TB] FAIL coll_host1: got %h/%h@%0d want 02/aaaa@256", ev_cmd[1], ev_data[1], ev_cyc[1] - c0);
            end
            total++;
            if (ev_cmd[2] !== 8'h03 || ev_data[2] !== 16'hBBBB || ev_cyc[2] != c0 + 257) begin
                bad++; $display("[TB] FAIL coll_host2: got %h/%h@%0d want 03/bbbb@257", ev_cmd[2], ev_data[2], ev_cyc[2] - c0);
            end
            total++;
            if (ev_cmd[3] !== 8'h01 || ev_data[3] !== 16'h0200 || ev_cyc[3] != c0 + 258) begin
                bad++; $display("[TB] FAIL coll_tune: got %h/%h@%0d want 01/0200@258", ev_cmd[3], ev_data[3], ev_cyc[3] - c0);
            end
        end
        total++;
        if (seq_overrun !== 1'b0) begin
            bad++; $display("[TB] FAIL coll_overrun: got %b want 0", seq_overrun);
        end
        send(8'h49, 16'h0000);
    endtask

    task automatic test_overrun();
        int c0;
        int tunes;
        int t_cyc;
        logic [15:0] t_data;
        logic [2:0]  t_step;
        clear_log();
        send(8'h49, 16'h0033);
        c0 = cyc;
        wait_cyc(c0 + 250);
        in_cmd_word  = 8'h02;
        in_data_word = 16'h0000;
        in_cmd_valid = 1'b1;
        wait_cyc(c0 + 520);
        in_cmd_valid = 1'b0;
        wait_cyc(c0 + 530);
        total++;
        if (seq_overrun !== 1'b1) begin
            bad++; $display("[TB] FAIL overrun_set: got %b want 1", seq_overrun);
        end
        tunes  = 0;
        t_cyc  = 0;
        t_data = '0;
        t_step = '0;
        foreach (ev_cmd[i]) begin
            if (ev_cmd[i] == 8'h01) begin
                tunes++;
                t_cyc  = ev_cyc[i];
                t_data = ev_data[i];
                t_step = ev_step[i];
            end
        end
        total++;
        if (tunes != 2) begin
            bad++; $display("[TB] FAIL overrun_tunes: got %0d want 2", tunes);
        end
        total++;
        if (t_data !== 16'h0300 || t_step !== 3'd2 || t_cyc != c0 + 521) begin
            bad++; $display("[TB] FAIL overrun_tune: got %h step %0d @%0d want 0300 step 2 @521", t_data, t_step, t_cyc - c0);
        end
        send(8'h49, 16'h0033);
        total++;
        if (seq_overrun !== 1'b0 || seq_busy !== 1'b1) begin
            bad++; $display("[TB] FAIL overrun_clear: got ovr %b busy %b want 0 1", seq_overrun, seq_busy);
        end
        send(8'h49, 16'h0000);
    endtask

    task automatic test_stop_on_tick();
        int c0;
        clear_log();
        send(8'h49, 16'h0033);
        c0 = cyc;
        wait_cyc(c0 + 255);
        in_cmd_word  = 8'h49;
        in_data_word = 16'h0000;
        in_cmd_valid = 1'b1;
        @(negedge clk);
        in_cmd_valid = 1'b0;
        repeat (300) @(negedge clk);
        total++;
        if (ev_cyc.size() != 1) begin
            bad++; $display("[TB] FAIL stop_tick_count: got %0d want 1", ev_cyc.size());
        end
        total++;
        if (seq_busy !== 1'b0) begin
            bad++; $display("[TB] FAIL stop_tick_busy: got %b want 0", seq_busy);
        end
        clear_log();
        send(8'h49, 16'h0031);
        c0 = cyc;
        repeat (5) @(negedge clk);
        total++;
        if (ev_cyc.size() != 1) begin
            bad++; $display("[TB] FAIL restart_count: got %0d want 1", ev_cyc.size());
        end else begin
            total++;
            if (ev_data[0] !== 16'h0100 || ev_cyc[0] != c0 + 1) begin
                bad++; $display("[TB] FAIL restart_ram: got %h@%0d want 0100@1", ev_data[0], ev_cyc[0] - c0);
            end
        end
        send(8'h49, 16'h0000);
    endtask

    task automatic test_clamp();
        clear_log();
        send(8'h49, 16'h00F1);
        repeat (2088) @(negedge clk);
        total++;
        if (ev_cyc.size() != 8) begin
            bad++; $display("[TB] FAIL clamp_count: got %0d want 8", ev_cyc.size());
        end else begin
            total++;
            if (ev_data[5] !== 16'hBEEF || ev_data[4] !== 16'h0000 || ev_data[3] !== 16'h0400) begin
                bad++; $display("[TB] FAIL clamp_data: got %h %h %h want 0400 0000 beef", ev_data[3], ev_data[4], ev_data[5]);
            end
            total++;
            if (ev_step[7] !== 3'd7) begin
                bad++; $display("[TB] FAIL clamp_last: got %0d want 7", ev_step[7]);
            end
        end
        total++;
        if (seq_busy !== 1'b0) begin
            bad++; $display("[TB] FAIL clamp_busy: got %b want 0", seq_busy);
        end
        send(8'h49, 16'h0000);
    endtask

    task automatic test_reset_midrun();
        int c0;
        send(8'h49, 16'h0033);
        c0 = cyc;
        wait_cyc(c0 + 300);
        total++;
        if (seq_busy !== 1'b1 || seq_step !== 3'd1) begin
            bad++; $display("[TB] FAIL pre_reset: got busy %b step %0d want 1 1", seq_busy, seq_step);
        end
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_cmd_valid !== 1'b0 || out_cmd_word !== 8'h00 || out_data_word !== 16'h0000) begin
            bad++; $display("[TB] FAIL async_reset_out: got %b %h/%h want 0 00/0000", out_cmd_valid, out_cmd_word, out_data_word);
        end
        total++;
        if (seq_busy !== 1'b0 || seq_step !== 3'd0 || seq_overrun !== 1'b0) begin
            bad++; $display("[TB] FAIL async_reset_status: got %b/%0d/%b want 0/0/0", seq_busy, seq_step, seq_overrun);
        end
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        clear_log();
        repeat (300) @(negedge clk);
        total++;
        if (ev_cyc.size() != 0) begin
            bad++; $display("[TB] FAIL post_reset_quiet: got %0d outputs want 0", ev_cyc.size());
        end
        total++;
        if (seq_busy !== 1'b0) begin
            bad++; $display("[TB] FAIL post_reset_busy: got %b want 0", seq_busy);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_run_loop();
        test_one_shot();
        test_back_to_back();
        test_overrun();
        test_stop_on_tick();
        test_clamp();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
